// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, round counts and helpers for the AES round sequencer
//   klen_e        key-length codes carried on klen_i
//   NR_128/192/256 round counts per key length
//   seq_state_e   sequencer FSM encoding
//   nr_of()       round count for a key-length code (0 for the illegal code)
package aes_pkg;

  localparam int AES_DW = 128;
  localparam int AES_KW = 256;

  typedef enum logic [1:0] {
    KLEN_128 = 2'b00,
    KLEN_192 = 2'b01,
    KLEN_256 = 2'b10,
    KLEN_BAD = 2'b11
  } klen_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic [3:0] nr_of(input logic [1:0] klen);
    case (klen)
      KLEN_128: nr_of = NR_128;
      KLEN_192: nr_of = NR_192;
      KLEN_256: nr_of = NR_256;
      default:  nr_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// rtl/aes_round_counter.sv - round index register with load, increment and last-round compare
//   clk, rst_n  clock, asynchronous active-low reset
//   load        start of a block: idx <= 1
//   inc         advance to the next round (saturates at nr)
//   clr         return idx to 0 (idle)
//   nr          round count of the block in flight
//   idx         current round number, 0 when idle
//   last        idx == nr for a block in flight
module aes_round_counter
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] nr,
  output logic [3:0] idx,
  output logic       last
);

  logic [3:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 4'd0;
    end else if (clr) begin
      idx_q <= 4'd0;
    end else if (load) begin
      idx_q <= 4'd1;
    end else if (inc && (idx_q < nr)) begin
      idx_q <= idx_q + 4'd1;
    end
  end

  assign idx = idx_q;
  // The idx != 0 term keeps an illegal key length (nr == 0) from looking like a last round.
  assign last = (idx_q != 4'd0) && (idx_q == nr);

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES encrypt controller around an external round/key-expansion datapath
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake for din_i/key_i/klen_i
//   din_i, key_i, klen_i    plaintext, MSB-aligned cipher key, key-length code
//   rnd_state_o/rnd_key_o   state and round key of the current round, to the datapath
//   rnd_idx_o/rnd_last_o    current round number (0 idle) and last-round flag
//   rnd_res_i               combinational round result
//   ks_key_i                round key for round rnd_idx_o+1 from the key-expansion step
//   out_valid/out_ready     result handshake
//   dout_o, err_o           ciphertext, illegal-key-length flag (dout_o forced to 0)
//   busy_o                  high while a block is running or waiting to be taken
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int DW = AES_DW,
  parameter int KW = AES_KW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din_i,
  input  logic [KW-1:0] key_i,
  input  logic [1:0]    klen_i,
  output logic [DW-1:0] rnd_state_o,
  output logic [DW-1:0] rnd_key_o,
  output logic [3:0]    rnd_idx_o,
  output logic          rnd_last_o,
  input  logic [DW-1:0] rnd_res_i,
  input  logic [DW-1:0] ks_key_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout_o,
  output logic          err_o,
  output logic          busy_o
);

  seq_state_e    state_q, state_d;
  logic [1:0]    klen_q;
  logic [DW-1:0] blk_q;
  logic [DW-1:0] key_q;
  logic [DW-1:0] dout_q;
  logic          err_q;

  logic          accept;
  logic          cnt_load, cnt_inc, cnt_clr;
  logic          cnt_last;
  logic [3:0]    cnt_idx;

  aes_round_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .nr    (nr_of(klen_q)),
    .idx   (cnt_idx),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          if (klen_i == KLEN_BAD) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RUN;
            cnt_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round key register holds the key for round rnd_idx. For AES-256 round 1 uses the
  // second half of the cipher key directly; for the shorter keys the expansion step
  // derives it from key_i while rnd_idx_o is still 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      klen_q <= 2'b00;
      blk_q  <= '0;
      key_q  <= '0;
      dout_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      blk_q  <= din_i ^ key_i[KW-1 -: DW];
      klen_q <= klen_i;
      key_q  <= (klen_i == KLEN_256) ? key_i[KW-DW-1:0] : ks_key_i;
      err_q  <= (klen_i == KLEN_BAD);
      if (klen_i == KLEN_BAD) begin
        dout_q <= '0;
      end
    end else if (state_q == ST_RUN) begin
      blk_q <= rnd_res_i;
      key_q <= ks_key_i;
      if (cnt_last) begin
        dout_q <= rnd_res_i;
      end
    end
  end

  // Gating with rst_n keeps in_ready low while reset is held.
  assign in_ready    = rst_n && (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign dout_o      = dout_q;
  assign err_o       = err_q;
  assign rnd_state_o = blk_q;
  assign rnd_key_o   = key_q;
  assign rnd_idx_o   = cnt_idx;
  assign rnd_last_o  = cnt_last;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed FIPS-197 vector bench with behavioural round and key-expansion model
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din_i;
  logic [255:0] key_i;
  logic [1:0]   klen_i;
  logic [127:0] rnd_state_o;
  logic [127:0] rnd_key_o;
  logic [3:0]   rnd_idx_o;
  logic         rnd_last_o;
  logic [127:0] rnd_res_i;
  logic [127:0] ks_key_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout_o;
  logic         err_o;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] w_drv [0:59];
  logic [31:0] w_run [0:59];

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_round_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din_i       (din_i),
    .key_i       (key_i),
    .klen_i      (klen_i),
    .rnd_state_o (rnd_state_o),
    .rnd_key_o   (rnd_key_o),
    .rnd_idx_o   (rnd_idx_o),
    .rnd_last_o  (rnd_last_o),
    .rnd_res_i   (rnd_res_i),
    .ks_key_i    (ks_key_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout_o      (dout_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq = a;
    logic [7:0] v  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      v  = gmul(v, sq);
    end
    if (a == 8'h00) v = 8'h00;
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [0:15];
    logic [7:0] t [0:15];
    logic [7:0] m [0:15];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        t[4*c+rw] = b[4*((c+rw)%4)+rw];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int rw = 0; rw < 4; rw++) m[4*c+rw] = t[4*c+rw];
      end else begin
        m[4*c+0] = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
        m[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
        m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
        m[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i];
    return r ^ k;
  endfunction

  task automatic expand(input logic [1:0] kl, input logic [255:0] key);
    int nk;
    logic [31:0] tmp;
    logic [7:0] rc;
    nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    for (int i = 0; i < 60; i++) w_drv[i] = 32'h0;
    for (int i = 0; i < nk; i++) w_drv[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nk+7); i++) begin
      tmp = w_drv[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w_drv[i] = w_drv[i-nk] ^ tmp;
    end
  endtask

  task automatic latch_sched();
    for (int i = 0; i < 60; i++) w_run[i] = w_drv[i];
  endtask

  always_comb begin
    int r;
    r = int'(rnd_idx_o) + 1;
    if (rnd_idx_o == 4'd0) ks_key_i = {w_drv[4], w_drv[5], w_drv[6], w_drv[7]};
    else if (r <= 14)      ks_key_i = {w_run[4*r], w_run[4*r+1], w_run[4*r+2], w_run[4*r+3]};
    else                   ks_key_i = '0;
  end

  assign rnd_res_i = aes_round(rnd_state_o, rnd_key_o, rnd_last_o);

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] kl, input logic [255:0] key, input logic [127:0] pt);
    din_i    = pt;
    key_i    = key;
    klen_i   = kl;
    in_valid = 1'b1;
    expand(kl, key);
  endtask

  task automatic run_one(input string tag, input logic [1:0] kl, input logic [255:0] key,
                         input logic [127:0] pt, input logic [127:0] ct, input logic exp_err,
                         input int hold);
    int nr, cyc, maxidx, lastidx;
    logic [127:0] held;
    nr = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 0;
    @(negedge clk);
    drive_req(kl, key, pt);
    check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    latch_sched();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din_i    = '1;
    key_i    = '1;
    klen_i   = ~kl;
    cyc = 1; maxidx = 0; lastidx = 0;
    while (1) begin
      if (int'(rnd_idx_o) > maxidx) maxidx = int'(rnd_idx_o);
      if (rnd_last_o) lastidx = int'(rnd_idx_o);
      if (out_valid || cyc >= 40) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_out_valid"}, 128'(out_valid), 128'd1);
    check_eq({tag, "_latency"}, 128'(cyc), 128'(nr + 1));
    check_eq({tag, "_dout"}, dout_o, ct);
    check_eq({tag, "_err"}, 128'(err_o), 128'(exp_err));
    check_eq({tag, "_max_idx"}, 128'(maxidx), 128'(nr));
    check_eq({tag, "_last_idx"}, 128'(lastidx), 128'(nr));
    held = dout_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_dout"}, dout_o, held);
      check_eq({tag, "_hold_err"}, 128'(err_o), 128'(exp_err));
      check_eq({tag, "_hold_vr"}, {126'd0, out_valid, in_ready}, 128'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_drained"}, {126'd0, out_valid, in_ready}, 128'b01);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc [0:2];
    logic [1:0]   b_kl [0:2];
    logic [255:0] b_key [0:2];
    logic [127:0] b_ct [0:2];
    int ki, ko, waitc;
    logic pending;

    for (int i = 0; i < 60; i++) begin w_drv[i] = 32'h0; w_run[i] = 32'h0; end
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din_i = '0; key_i = '0; klen_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", {123'd0, out_valid, err_o, busy_o, in_ready, rnd_last_o}, 128'd0);
    check_eq("rst_idx", 128'(rnd_idx_o), 128'd0);
    check_eq("rst_dout", dout_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", 128'(in_ready), 128'd1);

    run_one("c1", 2'b00, K128, PT, CT128, 1'b0, 0);
    run_one("c2", 2'b01, K192, PT, CT192, 1'b0, 5);
    run_one("c3", 2'b10, K256, PT, CT256, 1'b0, 0);
    run_one("bad", 2'b11, K128, PT, 128'd0, 1'b1, 2);

    // Reset in the middle of a block, then the same block again
    @(negedge clk);
    drive_req(2'b00, K128, PT);
    latch_sched();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitc = 0;
    while (rnd_idx_o != 4'd6 && waitc < 20) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    check_eq("mid_reach6", 128'(rnd_idx_o), 128'd6);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {123'd0, out_valid, err_o, busy_o, in_ready, rnd_last_o}, 128'd0);
    check_eq("mid_rst_idx", 128'(rnd_idx_o), 128'd0);
    check_eq("mid_rst_regs", rnd_state_o | rnd_key_o | dout_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("post_rst", 2'b00, K128, PT, CT128, 1'b0, 0);

    // Back-to-back blocks with the consumer always ready
    b_kl[0] = 2'b00; b_key[0] = K128; b_ct[0] = CT128;
    b_kl[1] = 2'b01; b_key[1] = K192; b_ct[1] = CT192;
    b_kl[2] = 2'b10; b_key[2] = K256; b_ct[2] = CT256;
    for (int i = 0; i < 3; i++) acc[i] = 0;
    ki = 0; ko = 0; pending = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drive_req(b_kl[0], b_key[0], PT);
    for (int c = 0; c < 80 && ko < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (pending) begin
        if (ki < 3) drive_req(b_kl[ki], b_key[ki], PT);
        else in_valid = 1'b0;
        pending = 1'b0;
      end
      if (out_valid) begin
        check_eq($sformatf("b2b_dout%0d", ko), dout_o, b_ct[ko]);
        ko++;
      end
      if (in_ready && in_valid && ki < 3) begin
        acc[ki] = c;
        latch_sched();
        ki++;
        pending = 1'b1;
      end
    end
    check_eq("b2b_count", 128'(ko), 128'd3);
    check_eq("b2b_gap01", 128'(acc[1] - acc[0]), 128'd12);
    check_eq("b2b_gap12", 128'(acc[2] - acc[1]), 128'd14);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
